// File: rtl/d_latch_bank_pkg.sv
// Shared constants and helpers for the d_latch_bank latch-emulation slice.
package d_latch_bank_pkg;

  // Reset value applied to every bit of a lane unless overridden.
  localparam logic DEFAULT_RESET_BIT = 1'b0;

  // Bit offset of a lane inside a packed multi-lane bus.
  function automatic int lane_offset(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/d_latch_bank_if.sv
// Bundle of the per-lane data, enable and status signals of a latch bank.
interface d_latch_bank_if #(
  parameter int WIDTH     = 1,
  parameter int NUM_LANES = 1
);

  logic [NUM_LANES*WIDTH-1:0] d;
  logic [NUM_LANES-1:0]       enable;
  logic [NUM_LANES*WIDTH-1:0] q;
  logic [NUM_LANES-1:0]       is_open;
  logic [NUM_LANES-1:0]       close_evt;

  modport master (
    output d,
    output enable,
    input  q,
    input  is_open,
    input  close_evt
  );

  modport slave (
    input  d,
    input  enable,
    output q,
    output is_open,
    output close_evt
  );

endinterface

// File: rtl/d_latch_lane.sv
// One lane of the emulated latch: hold flops plus a combinational bypass,
// with registered open status and a one-shot close pulse.
module d_latch_lane
  import d_latch_bank_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  output logic             is_open,
  output logic             close_evt
);

  logic [WIDTH-1:0] hold_q;

  // Capture d on every open edge; track enable and flag the 1->0 transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q    <= RESET_VALUE;
      is_open   <= 1'b0;
      close_evt <= 1'b0;
    end else begin
      if (enable) begin
        hold_q <= d;
      end
      is_open   <= enable;
      close_evt <= is_open & ~enable;
    end
  end

  // Transparent while enabled, held value otherwise; reset wins over both.
  always_comb begin
    q = hold_q;
    if (!rst_n) begin
      q = RESET_VALUE;
    end else if (enable) begin
      q = d;
    end
  end

endmodule

// File: rtl/d_latch_bank.sv
// Bank of independent emulated D latches; slices the shared bus into lanes.
module d_latch_bank
  import d_latch_bank_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               NUM_LANES   = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}}
) (
  input  logic          clk,
  input  logic          rst_n,
  d_latch_bank_if.slave bus
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int LSB = lane_offset(i, WIDTH);

    d_latch_lane #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .d         (bus.d[LSB +: WIDTH]),
      .enable    (bus.enable[i]),
      .q         (bus.q[LSB +: WIDTH]),
      .is_open   (bus.is_open[i]),
      .close_evt (bus.close_evt[i])
    );
  end

endmodule

// File: tb/tb_d_latch_bank.sv
// Self-checking bench for d_latch_bank: a 1x1-bit bank and a 4x8-bit bank
// compared against an edge-history model of latch behaviour.
module tb_d_latch_bank;
  import d_latch_bank_pkg::*;

  localparam logic [7:0] RV8 = 8'h3C;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  d_latch_bank_if #(.WIDTH(1), .NUM_LANES(1)) bus1 ();
  d_latch_bank_if #(.WIDTH(8), .NUM_LANES(4)) bus8 ();

  d_latch_bank #(.WIDTH(1), .NUM_LANES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  d_latch_bank #(.WIDTH(8), .NUM_LANES(4), .RESET_VALUE(RV8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int errors = 0;
  int checks = 0;

  // Model: value captured at the last open edge, and index of that edge.
  int         edge_n = 0;
  logic [7:0] m_val8 [4];
  int         m_en_edge8 [4] = '{-100, -100, -100, -100};
  logic       m_val1;
  int         m_en_edge1 = -100;

  // Record what each rising edge did to the model history.
  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      for (int l = 0; l < 4; l++) begin
        m_val8[l]     = RV8;
        m_en_edge8[l] = -100;
      end
      m_val1     = 1'b0;
      m_en_edge1 = -100;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (bus8.enable[l]) begin
          m_val8[l]     = bus8.d[l*8 +: 8];
          m_en_edge8[l] = edge_n;
        end
      end
      if (bus1.enable[0]) begin
        m_val1     = bus1.d[0];
        m_en_edge1 = edge_n;
      end
    end
  end

  function automatic logic [31:0] exp_q8();
    logic [31:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      if (!rst_n)               r[l*8 +: 8] = RV8;
      else if (bus8.enable[l])  r[l*8 +: 8] = bus8.d[l*8 +: 8];
      else                      r[l*8 +: 8] = m_val8[l];
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_open8();
    logic [3:0] r;
    for (int l = 0; l < 4; l++) r[l] = (m_en_edge8[l] == edge_n);
    return r;
  endfunction

  function automatic logic [3:0] exp_evt8();
    logic [3:0] r;
    for (int l = 0; l < 4; l++) r[l] = (m_en_edge8[l] == edge_n - 1);
    return r;
  endfunction

  function automatic logic exp_q1();
    if (!rst_n)          return 1'b0;
    if (bus1.enable[0])  return bus1.d[0];
    return m_val1;
  endfunction

  task automatic test_reset();
    rst_n       = 1'b0;
    bus1.d      = 1'b1;
    bus1.enable = 1'b1;
    bus8.d      = $urandom;
    bus8.enable = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus1.q !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_q1: got %b want 0", bus1.q);
      end
      checks++;
      if (bus1.is_open !== 1'b0 || bus1.close_evt !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_status1: open %b evt %b want 0 0", bus1.is_open, bus1.close_evt);
      end
      checks++;
      if (bus8.q !== {4{RV8}}) begin
        errors++; $display("[TB] FAIL reset_q8: got %h want %h", bus8.q, {4{RV8}});
      end
      checks++;
      if (bus8.is_open !== 4'h0 || bus8.close_evt !== 4'h0) begin
        errors++; $display("[TB] FAIL reset_status8: open %b evt %b want 0 0", bus8.is_open, bus8.close_evt);
      end
    end
    @(negedge clk);
    rst_n       = 1'b1;
    bus1.enable = 1'b0;
    bus8.enable = 4'h0;
    #1;
    checks++;
    if (bus1.q !== 1'b0 || bus8.q !== {4{RV8}}) begin
      errors++; $display("[TB] FAIL release_q: got %b %h want 0 %h", bus1.q, bus8.q, {4{RV8}});
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus1.q !== 1'b0 || bus1.is_open !== 1'b0 || bus1.close_evt !== 1'b0) begin
      errors++; $display("[TB] FAIL after_release1: q %b open %b evt %b want 0 0 0", bus1.q, bus1.is_open, bus1.close_evt);
    end
  endtask

  task automatic test_transparency();
    @(negedge clk);
    bus1.enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus1.d[0] = i[0];
      #1;
      checks++;
      if (bus1.q !== i[0] || bus1.q !== exp_q1()) begin
        errors++; $display("[TB] FAIL transp_q[%0d]: got %b want %b", i, bus1.q, i[0]);
      end
      checks++;
      if (bus1.is_open !== (m_en_edge1 == edge_n)) begin
        errors++; $display("[TB] FAIL transp_open[%0d]: got %b want %b", i, bus1.is_open, m_en_edge1 == edge_n);
      end
      if (i >= 1) begin
        checks++;
        if (bus1.is_open !== 1'b1) begin
          errors++; $display("[TB] FAIL transp_open_const[%0d]: got %b want 1", i, bus1.is_open);
        end
      end
      #2;
      bus1.d[0] = ~i[0];
      #1;
      checks++;
      if (bus1.q !== ~i[0]) begin
        errors++; $display("[TB] FAIL transp_mid[%0d]: got %b want %b", i, bus1.q, ~i[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold();
    int pulses;
    pulses      = 0;
    bus1.enable = 1'b1;
    bus1.d      = 1'b1;
    @(negedge clk);
    bus1.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus1.d = 1'($urandom);
      #1;
      checks++;
      if (bus1.q !== 1'b1) begin
        errors++; $display("[TB] FAIL hold_q[%0d]: got %b want 1", i, bus1.q);
      end
      checks++;
      if (bus1.close_evt !== (m_en_edge1 == edge_n - 1)) begin
        errors++; $display("[TB] FAIL hold_evt[%0d]: got %b want %b", i, bus1.close_evt, m_en_edge1 == edge_n - 1);
      end
      if (bus1.close_evt === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("[TB] FAIL hold_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_late_d();
    bus1.enable = 1'b1;
    bus1.d      = 1'b0;
    @(posedge clk);
    #2;
    bus1.d = 1'b1;
    #1;
    checks++;
    if (bus1.q !== 1'b1) begin
      errors++; $display("[TB] FAIL late_transp: got %b want 1", bus1.q);
    end
    @(negedge clk);
    bus1.enable = 1'b0;
    #1;
    checks++;
    if (bus1.q !== 1'b0) begin
      errors++; $display("[TB] FAIL late_hold0: got %b want 0", bus1.q);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus1.q !== 1'b0 || bus1.q !== exp_q1()) begin
      errors++; $display("[TB] FAIL late_hold1: got %b want 0", bus1.q);
    end
  endtask

  task automatic test_multi_lane();
    @(negedge clk);
    bus8.enable = 4'hF;
    bus8.d      = 32'h11223344;
    @(negedge clk);
    bus8.enable = 4'b0101;
    bus8.d      = 32'hAABBCCDD;
    #1;
    checks++;
    if (bus8.q !== 32'h11BB33DD) begin
      errors++; $display("[TB] FAIL multi_q_now: got %h want 11bb33dd", bus8.q);
    end
    checks++;
    if (bus8.is_open !== 4'hF) begin
      errors++; $display("[TB] FAIL multi_open_prev: got %b want 1111", bus8.is_open);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus8.q !== 32'h11BB33DD || bus8.q !== exp_q8()) begin
      errors++; $display("[TB] FAIL multi_q: got %h want 11bb33dd", bus8.q);
    end
    checks++;
    if (bus8.is_open !== 4'b0101) begin
      errors++; $display("[TB] FAIL multi_open: got %b want 0101", bus8.is_open);
    end
    checks++;
    if (bus8.close_evt !== 4'b1010) begin
      errors++; $display("[TB] FAIL multi_evt: got %b want 1010", bus8.close_evt);
    end
  endtask

  task automatic test_reset_mid_hold();
    @(negedge clk);
    bus8.enable = 4'b0001;
    bus8.d      = {24'($urandom), 8'h5A};
    @(negedge clk);
    bus8.enable = 4'h0;
    bus8.d      = $urandom;
    #1;
    checks++;
    if (bus8.q[7:0] !== 8'h5A) begin
      errors++; $display("[TB] FAIL midhold_q: got %h want 5a", bus8.q[7:0]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus8.q !== {4{RV8}}) begin
      errors++; $display("[TB] FAIL midhold_in_reset: got %h want %h", bus8.q, {4{RV8}});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus8.q !== {4{RV8}} || bus8.is_open !== 4'h0 || bus8.close_evt !== 4'h0) begin
      errors++; $display("[TB] FAIL midhold_release: q %h open %b evt %b want %h 0 0", bus8.q, bus8.is_open, bus8.close_evt, {4{RV8}});
    end
  endtask

  task automatic test_random();
    logic [3:0] prev_evt;
    prev_evt = bus8.close_evt;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      rst_n       = ($urandom_range(0, 15) != 0);
      bus8.enable = 4'($urandom);
      bus8.d      = $urandom;
      bus1.enable = 1'($urandom);
      bus1.d      = 1'($urandom);
      #1;
      checks++;
      if (bus8.q !== exp_q8()) begin
        errors++; $display("[TB] FAIL rand_q8[%0d]: got %h want %h", i, bus8.q, exp_q8());
      end
      checks++;
      if (bus8.is_open !== exp_open8()) begin
        errors++; $display("[TB] FAIL rand_open8[%0d]: got %b want %b", i, bus8.is_open, exp_open8());
      end
      checks++;
      if (bus8.close_evt !== exp_evt8()) begin
        errors++; $display("[TB] FAIL rand_evt8[%0d]: got %b want %b", i, bus8.close_evt, exp_evt8());
      end
      checks++;
      if ((bus8.close_evt & prev_evt) !== 4'h0) begin
        errors++; $display("[TB] FAIL rand_evt_consec[%0d]: got %b after %b want no overlap", i, bus8.close_evt, prev_evt);
      end
      prev_evt = bus8.close_evt;
      checks++;
      if (bus1.q !== exp_q1() || bus1.is_open !== (m_en_edge1 == edge_n) ||
          bus1.close_evt !== (m_en_edge1 == edge_n - 1)) begin
        errors++; $display("[TB] FAIL rand_lane1[%0d]: q %b open %b evt %b want %b %b %b", i,
                           bus1.q, bus1.is_open, bus1.close_evt, exp_q1(),
                           m_en_edge1 == edge_n, m_en_edge1 == edge_n - 1);
      end
      if ($urandom_range(0, 1) == 1) begin
        #2;
        bus8.d = $urandom;
        bus1.d = 1'($urandom);
        #1;
        checks++;
        if (bus8.q !== exp_q8() || bus1.q !== exp_q1()) begin
          errors++; $display("[TB] FAIL rand_mid[%0d]: got %h %b want %h %b", i, bus8.q, bus1.q, exp_q8(), exp_q1());
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run every scenario in order and report the totals.
  initial begin
    test_reset();
    test_transparency();
    test_hold();
    test_late_d();
    test_multi_lane();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
